write_visited_arbiter: RTL and testbench

WRITE_VISITED_ARBITER -- requirements
Module: write_visited_arbiter

---
 rtl/write_visited_arbiter.sv | 158 +++++++++++++++
 tb/tb_write_visited_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_visited_arbiter.sv
// Round-robin arbiter feeding a single-entry write register toward the
// visited-node writer, with a drain / settle / done flush sequence.
module write_visited_arbiter #(
    parameter int W_D     = 32,
    parameter int NUM_REQ = 4,
    parameter int W_CNT   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ*W_D-1:0] req_addr,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [W_D-1:0]         write_addr,
    output logic                   write_valid,
    input  logic                   write_ready,
    input  logic                   write_empty,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   busy,
    output logic [W_CNT-1:0]       write_count
);
    localparam int W_G = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, SETTLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [W_D-1:0]   waddr_q, waddr_d;
    logic             wvalid_q, wvalid_d;
    logic [W_G-1:0]   last_grant_q, last_grant_d;
    logic [W_CNT-1:0] count_q, count_d;
    logic             settled_q, settled_d;
    logic             flush_done_q, flush_done_d;

    logic             load_ok;
    logic             out_fire;
    logic             found;
    logic             hi_found;
    logic             grant;
    logic [W_G-1:0]   win;
    logic [W_G-1:0]   hi_idx;
    logic [W_G-1:0]   lo_idx;
    logic [W_D-1:0]   win_addr;

    assign out_fire = wvalid_q && write_ready;
    assign load_ok  = !wvalid_q || write_ready;

    // Lowest valid index above last_grant wins, else lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        found    = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (W_G'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = W_G'(i);
                end
                found  = 1'b1;
                lo_idx = W_G'(i);
            end
        end
        win = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (W_G'(i) == win) begin
                win_addr = req_addr[i*W_D +: W_D];
            end
        end
    end

    assign grant = RST && (state_q == RUN) && load_ok && found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        wvalid_d     = wvalid_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        settled_d    = settled_q;

        if (out_fire) begin
            wvalid_d = 1'b0;
            count_d  = count_q + W_CNT'(1);
        end
        if (grant) begin
            wvalid_d     = 1'b1;
            waddr_d      = win_addr;
            last_grant_d = win;
        end

        unique case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (load_ok) begin
                    state_d   = SETTLE;
                    settled_d = 1'b0;
                end
            end
            SETTLE: begin
                // settled_q marks that the first settle cycle has elapsed
                settled_d = 1'b1;
                if (settled_q && write_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        flush_done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= RUN;
            waddr_q      <= '0;
            wvalid_q     <= 1'b0;
            last_grant_q <= W_G'(NUM_REQ - 1);
            count_q      <= '0;
            settled_q    <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            wvalid_q     <= wvalid_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            settled_q    <= settled_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign write_addr  = waddr_q;
    assign write_valid = wvalid_q;
    assign write_count = count_q;
    assign flush_done  = flush_done_q;
    assign busy        = (state_q != RUN) || wvalid_q;

endmodule

// File: tb/tb_write_visited_arbiter.sv
// Bench for write_visited_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference model.
module tb_write_visited_arbiter;
    localparam int W_D     = 32;
    localparam int NUM_REQ = 4;
    localparam int W_CNT   = 4;

    localparam int P_RUN    = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_SETTLE = 2;
    localparam int P_DONE   = 3;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic [NUM_REQ*W_D-1:0] req_addr;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [W_D-1:0]         write_addr;
    logic                   write_valid;
    logic                   write_ready;
    logic                   write_empty;
    logic                   flush_req;
    logic                   flush_done;
    logic                   busy;
    logic [W_CNT-1:0]       write_count;

    logic [W_D-1:0] addr_arr [NUM_REQ];

    int errors = 0;
    int checks = 0;

    int             m_phase;
    int             m_lg;
    int             m_cnt;
    int             m_wait;
    bit             m_ov;
    bit             m_fd;
    logic [W_D-1:0] m_oa;

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*W_D +: W_D] = addr_arr[i];
        end
    end

    write_visited_arbiter #(
        .W_D(W_D),
        .NUM_REQ(NUM_REQ),
        .W_CNT(W_CNT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .req_addr(req_addr),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .write_addr(write_addr),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .write_empty(write_empty),
        .flush_req(flush_req),
        .flush_done(flush_done),
        .busy(busy),
        .write_count(write_count)
    );

    function automatic int exp_grant();
        int idx;
        if (!RST || m_phase != P_RUN) return -1;
        if (m_ov && !write_ready) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_lg + k) % NUM_REQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g < 0) return '0;
        return NUM_REQ'(1) << g;
    endfunction

    task automatic model_reset();
        m_phase = P_RUN;
        m_lg    = NUM_REQ - 1;
        m_cnt   = 0;
        m_wait  = 0;
        m_ov    = 1'b0;
        m_fd    = 1'b0;
        m_oa    = '0;
    endtask

    task automatic step();
        int             g;
        bit             fire;
        bit             ld;
        bit             fl;
        bit             we;
        logic [W_D-1:0] ga;
        g    = exp_grant();
        fire = m_ov && write_ready;
        ld   = !m_ov || write_ready;
        fl   = flush_req;
        we   = write_empty;
        ga   = '0;
        if (g >= 0) ga = addr_arr[g];
        @(posedge CLK);
        #1;
        if (fire) begin
            m_cnt = (m_cnt + 1) % (1 << W_CNT);
            m_ov  = 1'b0;
        end
        if (g >= 0) begin
            m_ov = 1'b1;
            m_oa = ga;
            m_lg = g;
        end
        case (m_phase)
            P_RUN:    if (fl) m_phase = P_DRAIN;
            P_DRAIN:  if (ld) begin m_phase = P_SETTLE; m_wait = 0; end
            P_SETTLE: begin
                m_wait++;
                if (m_wait >= 2 && we) m_phase = P_DONE;
            end
            default:  m_phase = P_RUN;
        endcase
        m_fd = (m_phase == P_DONE);
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        write_ready = 1'b1;
        write_empty = 1'b1;
        flush_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = '0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST         = 1'b0;
        req_valid   = '1;
        write_ready = 1'b1;
        write_empty = 1'b1;
        flush_req   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = 32'hdead_0000 + i;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (req_ready !== '0)
            $display("FAIL reset_ready: got %b expected 0", req_ready);
        checks++;
        if (write_valid !== 1'b0 || write_addr !== '0)
            $display("FAIL reset_wout: got %b/%h expected 0/0",
                     write_valid, write_addr);
        checks++;
        if (write_count !== '0 || flush_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_misc: cnt=%0d fd=%b busy=%b expected 0",
                     write_count, flush_done, busy);
        if (req_ready !== '0) errors++;
        if (write_valid !== 1'b0 || write_addr !== '0) errors++;
        if (write_count !== '0 || flush_done !== 1'b0 || busy !== 1'b0)
            errors++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid   = 4'b0001;
        addr_arr[0] = 32'h100;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (write_valid !== 1'b1 || write_addr !== 32'h100) begin
            errors++;
            $display("FAIL single_out: got %b/%h expected 1/100",
                     write_valid, write_addr);
        end
        step();
        checks++;
        if (write_count !== W_CNT'(1) || write_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got %0d/%b expected 1/0",
                     write_count, write_valid);
        end
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] want;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = 32'h1000 + 16 * i;
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            #1;
            want = NUM_REQ'(1) << (c % NUM_REQ);
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b expected %b",
                         c, req_ready, want);
            end
            if (c > 0) begin
                checks++;
                if (write_addr !== 32'h1000 + 16 * ((c - 1) % NUM_REQ)) begin
                    errors++;
                    $display("FAIL fair_addr%0d: got %h", c, write_addr);
                end
            end
            step();
        end
        req_valid = '0;
        step();
        checks++;
        if (write_count !== W_CNT'(8) || write_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_count: got %0d/%b expected 8/0",
                     write_count, write_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid   = 4'b0100;
        addr_arr[2] = 32'h200;
        addr_arr[0] = 32'h111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 0100", req_ready);
        end
        step();
        req_valid   = 4'b1011;
        write_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== '0 || write_valid !== 1'b1 ||
                write_addr !== 32'h200) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b %b %h expected 0000 1 200",
                         c, req_ready, write_valid, write_addr);
            end
            step();
        end
        req_valid   = '0;
        write_ready = 1'b1;
        step();
        checks++;
        if (write_count !== W_CNT'(1) || write_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got %0d/%b expected 1/0",
                     write_count, write_valid);
        end
        step();
        checks++;
        if (write_count !== W_CNT'(1)) begin
            errors++;
            $display("FAIL bp_once: got %0d expected 1", write_count);
        end
    endtask

    task automatic test_flush();
        logic [NUM_REQ-1:0] want;
        int                 pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = 32'h5000 + i;
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            flush_req   = (c == 2);
            write_ready = !(c == 3 || c == 4);
            write_empty = (c >= 9);
            #1;
            if (c <= 2) want = NUM_REQ'(1) << c;
            else if (c == 11) want = 4'b1000;
            else want = '0;
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL flush_ready%0d: got %b expected %b",
                         c, req_ready, want);
            end
            checks++;
            if (flush_done !== (c == 10)) begin
                errors++;
                $display("FAIL flush_done%0d: got %b expected %b",
                         c, flush_done, (c == 10));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 10)) begin
                errors++;
                $display("FAIL flush_busy%0d: got %b", c, busy);
            end
            if (flush_done === 1'b1) pulses++;
            if (c == 10) begin
                checks++;
                if (write_count !== W_CNT'(3)) begin
                    errors++;
                    $display("FAIL flush_count: got %0d expected 3",
                             write_count);
                end
            end
            step();
        end
        flush_req = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL flush_pulses: got %0d expected 1", pulses);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid   = 4'b0001;
        addr_arr[0] = 32'h77;
        repeat (17) step();
        checks++;
        if (write_count !== W_CNT'(0)) begin
            errors++;
            $display("FAIL wrap16: got %0d expected 0", write_count);
        end
        req_valid = '0;
        step();
        checks++;
        if (write_count !== W_CNT'(1)) begin
            errors++;
            $display("FAIL wrap17: got %0d expected 1", write_count);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        req_valid   = 4'b0010;
        addr_arr[1] = 32'h300;
        flush_req   = 1'b1;
        step();
        flush_req   = 1'b0;
        write_ready = 1'b0;
        write_empty = 1'b1;
        req_valid   = '1;
        #1;
        checks++;
        if (req_ready !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: got %b/%b expected 0000/1",
                     req_ready, busy);
        end
        RST = 1'b0;
        model_reset();
        #1;
        checks++;
        if (write_valid !== 1'b0 || write_addr !== '0 || req_ready !== '0 ||
            busy !== 1'b0 || flush_done !== 1'b0 || write_count !== '0) begin
            errors++;
            $display("FAIL midreset: v=%b a=%h r=%b b=%b fd=%b c=%0d",
                     write_valid, write_addr, req_ready, busy, flush_done,
                     write_count);
        end
        @(posedge CLK);
        #1;
        RST         = 1'b1;
        write_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant: got %b expected 0001",
                     req_ready);
        end
        step();
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (flush_done !== 1'b0) begin
                errors++;
                $display("FAIL stale_flush%0d: got %b expected 0",
                         c, flush_done);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] want;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid   = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = $urandom;
            write_ready = ($urandom_range(0, 9) < 7);
            write_empty = ($urandom_range(0, 1) == 1);
            flush_req   = ($urandom_range(0, 19) == 0);
            #1;
            want = exp_ready();
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL rnd_ready%0d: got %b expected %b",
                         c, req_ready, want);
            end
            checks++;
            if (write_valid !== m_ov || write_addr !== m_oa) begin
                errors++;
                $display("FAIL rnd_out%0d: got %b/%h expected %b/%h",
                         c, write_valid, write_addr, m_ov, m_oa);
            end
            checks++;
            if (write_count !== W_CNT'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_count%0d: got %0d expected %0d",
                         c, write_count, m_cnt);
            end
            checks++;
            if (flush_done !== m_fd ||
                busy !== (m_phase != P_RUN || m_ov)) begin
                errors++;
                $display("FAIL rnd_status%0d: fd=%b busy=%b phase=%0d",
                         c, flush_done, busy, m_phase);
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
